// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the mux_sel_arbiter slice.
// These are the FSM state encoding, the mux select values and the default burst sizing.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } mux_arb_state_t;

    localparam logic SEL_I0 = 1'b0;
    localparam logic SEL_I1 = 1'b1;

    localparam int DEFAULT_BURST_LEN = 4;
    localparam int DEFAULT_CNT_W     = 8;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two mux sources and mux_sel_arbiter.
// switch_cnt_out exists only when MUX_SEL_STATS_EN is defined.
interface mux_sel_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             req0_in;
    logic             req1_in;
    logic             last0_in;
    logic             last1_in;
    logic             sel_out;
    logic             gnt0_out;
    logic             gnt1_out;
    logic             valid_out;
    logic [CNT_W-1:0] burst_cnt_out;
`ifdef MUX_SEL_STATS_EN
    logic [15:0]      switch_cnt_out;
`endif

    // master is the requester side; slave is the arbiter itself
    modport master (
`ifdef MUX_SEL_STATS_EN
        input  switch_cnt_out,
`endif
        output req0_in, req1_in, last0_in, last1_in,
        input  sel_out, gnt0_out, gnt1_out, valid_out, burst_cnt_out
    );

    modport slave (
`ifdef MUX_SEL_STATS_EN
        output switch_cnt_out,
`endif
        input  req0_in, req1_in, last0_in, last1_in,
        output sel_out, gnt0_out, gnt1_out, valid_out, burst_cnt_out
    );

endinterface

// File: rtl/mux_sel_arbiter_burst_cnt.sv
// Beat counter for the current burst; flags the final permitted beat.
module mux_burst_cnt
    import mux_pkg::*;
#(
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             clear,
    input  logic             increment,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    // clear wins over increment so a re-grant always restarts at beat 0
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (increment) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin, burst-bounded arbiter driving the select line of a 2:1 mux.
// Optional: define MUX_SEL_STATS_EN to add the switch_cnt_out select-toggle counter.
module mux_sel_arbiter
    import mux_pkg::*;
#(
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input logic               clk_in,
    input logic               rst_n_in,
    mux_sel_arbiter_if.slave  bus
);

    mux_arb_state_t   state_q;
    mux_arb_state_t   state_d;
    logic             rr_last_q;
    logic             sel_q;
    logic             sel_d;
    logic             gnt0_q;
    logic             gnt1_q;
    logic             valid_q;
    logic             cnt_inc;
    logic             cnt_clear;
    logic             cnt_terminal;
    logic [CNT_W-1:0] burst_cnt;

    // Next-state decision: continue the burst, hand over, re-grant, or drop to IDLE
    always_comb begin
        state_d = IDLE;
        cnt_inc = 1'b0;
        case (state_q)
            GRANT0: begin
                if (bus.req0_in && !bus.last0_in && !cnt_terminal) begin
                    state_d = GRANT0;
                    cnt_inc = 1'b1;
                end else if (bus.req1_in) begin
                    state_d = GRANT1;
                end else if (bus.req0_in && !bus.last0_in) begin
                    state_d = GRANT0;
                end
            end
            GRANT1: begin
                if (bus.req1_in && !bus.last1_in && !cnt_terminal) begin
                    state_d = GRANT1;
                    cnt_inc = 1'b1;
                end else if (bus.req0_in) begin
                    state_d = GRANT0;
                end else if (bus.req1_in && !bus.last1_in) begin
                    state_d = GRANT1;
                end
            end
            default: begin
                if (bus.req0_in && bus.req1_in) begin
                    state_d = rr_last_q ? GRANT0 : GRANT1;
                end else if (bus.req0_in) begin
                    state_d = GRANT0;
                end else if (bus.req1_in) begin
                    state_d = GRANT1;
                end
            end
        endcase
    end

    // Select follows the granted source and holds its value through IDLE
    always_comb begin
        sel_d = sel_q;
        if (state_d == GRANT0) begin
            sel_d = SEL_I0;
        end else if (state_d == GRANT1) begin
            sel_d = SEL_I1;
        end
    end

    assign cnt_clear = !cnt_inc;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            sel_q     <= SEL_I0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt0_q  <= (state_d == GRANT0);
            gnt1_q  <= (state_d == GRANT1);
            valid_q <= (state_d != IDLE);
            if (state_d == GRANT0) begin
                rr_last_q <= 1'b0;
            end else if (state_d == GRANT1) begin
                rr_last_q <= 1'b1;
            end
        end
    end

    mux_burst_cnt #(
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) u_burst_cnt (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .clear     (cnt_clear),
        .increment (cnt_inc),
        .count     (burst_cnt),
        .terminal  (cnt_terminal)
    );

`ifdef MUX_SEL_STATS_EN
    logic [15:0] switch_cnt_q;

    // Counts select toggles, saturating rather than wrapping
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            switch_cnt_q <= '0;
        end else if ((sel_d != sel_q) && (switch_cnt_q != 16'hFFFF)) begin
            switch_cnt_q <= switch_cnt_q + 16'd1;
        end
    end

    assign bus.switch_cnt_out = switch_cnt_q;
`endif

    assign bus.sel_out       = sel_q;
    assign bus.gnt0_out      = gnt0_q;
    assign bus.gnt1_out      = gnt1_q;
    assign bus.valid_out     = valid_q;
    assign bus.burst_cnt_out = burst_cnt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed self-checking bench for mux_sel_arbiter (BURST_LEN=4).
// Extra switch counter checks are compiled in when MUX_SEL_STATS_EN is defined.
module tb_mux_sel_arbiter;
    import mux_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    mux_sel_arbiter_if #(.CNT_W(8)) bus ();

    mux_sel_arbiter #(
        .BURST_LEN (4),
        .CNT_W     (8)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic l0, input logic l1);
        bus.req0_in  = r0;
        bus.req1_in  = r1;
        bus.last0_in = l0;
        bus.last1_in = l1;
    endtask

    task automatic checkVal(input string name, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic e_sel, input logic e_g0,
                               input logic e_g1, input logic e_v, input logic [7:0] e_cnt);
        checkVal({tag, ".sel"},   16'(bus.sel_out),       16'(e_sel));
        checkVal({tag, ".gnt0"},  16'(bus.gnt0_out),      16'(e_g0));
        checkVal({tag, ".gnt1"},  16'(bus.gnt1_out),      16'(e_g1));
        checkVal({tag, ".valid"}, 16'(bus.valid_out),     16'(e_v));
        checkVal({tag, ".cnt"},   16'(bus.burst_cnt_out), 16'(e_cnt));
    endtask

    initial begin
        logic src;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset held for three cycles, then idle with no requests
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            checkVal($sformatf("idle%0d.state", i), 16'(dut.state_q), 16'(IDLE));
        end

        // Lone requester: bursts of four restart back to back
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("single%0d", i), 1'b0, 1'b1, 1'b0, 1'b1, 8'(i % 4));
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("single_drop", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Fresh reset so source 0 wins the first tie, then full contention
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            tick();
            src = 1'((i / 4) % 2);
            checkOutput($sformatf("cont%0d", i), src, !src, src, 1'b1, 8'(i % 4));
`ifdef MUX_SEL_STATS_EN
            if (i == 23) begin
                checkVal("stats.switch3rounds", bus.switch_cnt_out, 16'd5);
            end
`endif
        end

        // Early last from source 1 at beat 1 hands over immediately
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("early_last", 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);

        // last1 during source 0's grant is ignored
        tick();
        checkOutput("foreign_last", 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);

        // Advance to GRANT1 beat 2, then reset asynchronously mid-cycle
        tick();
        checkOutput("pre_rst_a", 1'b0, 1'b1, 1'b0, 1'b1, 8'd2);
        tick();
        checkOutput("pre_rst_b", 1'b0, 1'b1, 1'b0, 1'b1, 8'd3);
        tick();
        checkOutput("pre_rst_c", 1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
        tick();
        checkOutput("pre_rst_d", 1'b1, 1'b0, 1'b1, 1'b1, 8'd1);
        tick();
        checkOutput("pre_rst_e", 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
`ifdef MUX_SEL_STATS_EN
        checkVal("stats.async_rst", bus.switch_cnt_out, 16'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst", 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);

        // Source 0 withdraws: hand over to source 1
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("handover", 1'b1, 1'b0, 1'b1, 1'b1, 8'd0);

        // Simultaneous last and withdraw: one release into IDLE, select held at 1
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("last_and_drop", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("idle_hold_sel", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Upstream control stage for the 2:1 mux (mux_if).
- Arbitrates between two data sources, requester 0 on i0 and requester 1 on i1, using round-robin priority with bounded bursts.
- Drives the mux select line from a register, plus per-source grants and a valid qualifier that tells the downstream consumer when y_out carries granted data.

Parameters:
- BURST_LEN, 4: maximum consecutive cycles one source may hold the grant; legal range 1..255.
- CNT_W, 8: width of the burst counter; must satisfy 2**CNT_W > BURST_LEN.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- req0_in  input  1  source 0 (i0) requests the mux.
- req1_in  input  1  source 1 (i1) requests the mux.
- last0_in  input  1  source 0 signals its final beat; sampled only while gnt0_out=1.
- last1_in  input  1  source 1 signals its final beat; sampled only while gnt1_out=1.
- sel_out  output  1  mux select: 0 selects i0, 1 selects i1; connects to mux_if sel_in.
- gnt0_out  output  1  source 0 owns the mux this cycle.
- gnt1_out  output  1  source 1 owns the mux this cycle.
- valid_out  output  1  gnt0_out | gnt1_out; y_out is meaningful this cycle.
- burst_cnt_out  output  CNT_W  beats completed in the current burst (0-based).

Behaviour:
- Reset, asynchronous while rst_n_in=0:
  - state=IDLE; sel_out=0; gnt0_out=0; gnt1_out=0; valid_out=0; burst_cnt_out=0.
  - Round-robin pointer rr_last=1, so source 0 wins the first tie.
- All outputs are registered. Latency from request to grant is 1 cycle: req sampled at edge N, grant visible after edge N.
- States: IDLE, GRANT0, GRANT1.
  - gnt0_out=1 only in GRANT0; gnt1_out=1 only in GRANT1; never both.
- Arbitration, evaluated in IDLE and at every release point:
  - Only one request asserted: grant that requester.
  - Both asserted: grant the source that is not rr_last.
  - On entering GRANTx: rr_last<=x, sel_out<=x, burst_cnt_out<=0.
- GRANTx, evaluated each cycle. The burst releases when any of the following holds:
  - reqx_in=0;
  - lastx_in=1;
  - burst_cnt_out==BURST_LEN-1.
- Without release: burst_cnt_out increments by 1.
- On release: re-arbitrate in the same edge with no idle bubble.
  - The other source wins if it requests.
  - Otherwise the same source is re-granted only if it still requests and did not assert last; its counter restarts at 0.
  - Otherwise go to IDLE.
- sel_out holds its last value in IDLE, which avoids a needless toggle on the mux.
- BURST_LEN=1: every beat is a release point, giving strict alternation under contention.
- Counter arithmetic is unsigned and never wraps, because release occurs at BURST_LEN-1.
- Simultaneous lastx_in and reqx_in=0: treated as a single release.
- Reset asserted mid-burst: immediate return to the reset values; no partial beat is counted.
- lastx_in outside its own grant: ignored.

Optional Feature:
- Macro: MUX_SEL_STATS_EN.
- Defined:
  - Adds output switch_cnt_out [15:0], reset to 0.
  - Increments on every edge where sel_out changes value.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_pkg:
  - state enum mux_arb_state_t {IDLE, GRANT0, GRANT1};
  - constants SEL_I0=1'b0, SEL_I1=1'b1;
  - default BURST_LEN value.
- Sub-module mux_burst_cnt:
  - Inputs: clear, increment. Output: terminal flag (count==BURST_LEN-1).
  - Instantiated once.
- FSM and round-robin pointer stay in the top module.

Test Plan:
- Reset/idle: hold rst_n_in=0 for 3 cycles, then release with no requests.
  - Expect: all outputs 0, state IDLE, for 5 cycles.
- Single requester, BURST_LEN=4: req0_in=1 held for 10 cycles.
  - Expect: gnt0_out=1 from cycle 1.
  - Expect: burst_cnt_out sequence 0,1,2,3,0,1,2,3 with no gap.
  - Expect: sel_out=0 throughout.
- Contention: req0_in=req1_in=1 held.
  - Expect: 4 beats of gnt0_out (sel_out=0), then 4 beats of gnt1_out (sel_out=1), alternating.
  - Expect: valid_out=1 continuously.
- Early last: during GRANT1 at burst_cnt_out=1, pulse last1_in with req0_in=1.
  - Expect: gnt0_out=1 on the next cycle and burst_cnt_out=0.
- Mid-burst reset: assert rst_n_in=0 asynchronously while gnt1_out=1 and burst_cnt_out=2.
  - Expect: outputs 0 immediately, without waiting for a clock edge.
  - After release with both requesting: source 0 is granted first.
- MUX_SEL_STATS_EN: run 3 full contention rounds.
  - Expect: switch_cnt_out=5. The sel_out sequence is 0→1→0→1→0→1, and the initial grant to source 0 is not a change.
